// File: rtl/ram_sp_arbiter_pkg.sv
// ram_sp_arbiter_pkg
//   Shared definitions for the two-requester single-port RAM arbiter:
//   sequencer state encoding, requester identifiers and a small helper
//   that says in which states a new request may be accepted.
//   No ports (package).

package ram_sp_arbiter_pkg;

    // Sequencer states: idle, write in flight, read address phase,
    // read data phase.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD1  = 2'd2,
        ST_RD2  = 2'd3
    } state_t;

    // Requester identifiers; also the encoding of the last-grant pointer.
    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    // A new access may start in every state except the first read cycle,
    // where the RAM has not yet registered its output.
    function automatic logic accept_allowed(input state_t s);
        return s != ST_RD1;
    endfunction

endpackage

// File: rtl/ram_sp_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin grant. A single requester always wins; when both
//   request, the one not granted last wins. The last-grant pointer moves
//   only when the owner reports that the granted request was accepted.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset (pointer -> ID_M1)
//   req     in   [1:0] request vector, bit i = requester i
//   update  in   granted request accepted this cycle
//   gnt     out  [1:0] one-hot (or zero) combinational grant

module rr_arb2
    import ram_sp_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last;

    // NOTE: every output of a combinational block gets a default first, so
    // no path through it can leave gnt unassigned and infer a latch.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == ID_M1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Reset to ID_M1 so that m0 wins the first conflict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last <= ID_M1;
        end else if (update) begin
            last <= gnt[1] ? ID_M1 : ID_M0;
        end
    end

endmodule

// File: rtl/ram_sp_arbiter.sv
// ram_sp_arbiter
//   Serialises the accesses of two valid/ready masters onto one
//   single-port synchronous RAM. RAM controls, address and write data are
//   registered; the arbiter drives the shared data bus only while ram_we
//   is high. Writes occupy one cycle, reads two; the next access may be
//   accepted in the last cycle of the current one, so there is no bubble.
//   Read data is returned to the requester that issued the read as a
//   one-cycle rsp_valid pulse with rsp_rdata held until the next response.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   mX_req_valid/ready         request handshake (X = 0, 1)
//   mX_req_we/addr/wdata       request fields (1 = write)
//   mX_rsp_valid/rdata         read response
//   ram_address                registered RAM address
//   ram_data                   bidirectional RAM data bus
//   ram_cs/ram_we/ram_oe       registered RAM controls

module ram_sp_arbiter
    import ram_sp_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic                  m0_req_we,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    input  logic [DATA_WIDTH-1:0] m0_req_wdata,
    output logic                  m0_rsp_valid,
    output logic [DATA_WIDTH-1:0] m0_rsp_rdata,

    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic                  m1_req_we,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    input  logic [DATA_WIDTH-1:0] m1_req_wdata,
    output logic                  m1_rsp_valid,
    output logic [DATA_WIDTH-1:0] m1_rsp_rdata,

    output logic [ADDR_WIDTH-1:0] ram_address,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    state_t                state;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rd_id;      // requester owning the read in flight

    logic [1:0]            gnt;
    logic                  accept;
    logic                  acc_id;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({m1_req_valid, m0_req_valid}),
        .update (accept),
        .gnt    (gnt)
    );

    assign m0_req_ready = accept_allowed(state) & gnt[0];
    assign m1_req_ready = accept_allowed(state) & gnt[1];
    assign accept       = m0_req_ready | m1_req_ready;

    // Grant is one-hot, so the accepted requester's fields are a plain mux.
    assign acc_id    = m1_req_ready ? ID_M1 : ID_M0;
    assign acc_we    = m1_req_ready ? m1_req_we    : m0_req_we;
    assign acc_addr  = m1_req_ready ? m1_req_addr  : m0_req_addr;
    assign acc_wdata = m1_req_ready ? m1_req_wdata : m0_req_wdata;

    // The RAM drives the bus whenever ram_we is low, so the arbiter must
    // release it in exactly those cycles.
    assign ram_data = ram_we ? wdata_q : {DATA_WIDTH{1'bz}};

    // NOTE: all state below is sequential and updated with non-blocking
    // assignments, so every register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ram_cs       <= 1'b0;
            ram_we       <= 1'b0;
            ram_oe       <= 1'b0;
            ram_address  <= '0;
            wdata_q      <= '0;
            rd_id        <= ID_M0;
            m0_rsp_valid <= 1'b0;
            m1_rsp_valid <= 1'b0;
            m0_rsp_rdata <= '0;
            m1_rsp_rdata <= '0;
        end else begin
            m0_rsp_valid <= 1'b0;
            m1_rsp_valid <= 1'b0;

            // The RAM registered its output at the end of RD1; take it now.
            if (state == ST_RD2) begin
                if (rd_id == ID_M1) begin
                    m1_rsp_rdata <= ram_data;
                    m1_rsp_valid <= 1'b1;
                end else begin
                    m0_rsp_rdata <= ram_data;
                    m0_rsp_valid <= 1'b1;
                end
            end

            if (state == ST_RD1) begin
                state <= ST_RD2;
            end else if (accept) begin
                ram_cs      <= 1'b1;
                ram_address <= acc_addr;
                if (acc_we) begin
                    state   <= ST_WR;
                    ram_we  <= 1'b1;
                    ram_oe  <= 1'b0;
                    wdata_q <= acc_wdata;
                end else begin
                    state   <= ST_RD1;
                    ram_we  <= 1'b0;
                    ram_oe  <= 1'b1;
                    rd_id   <= acc_id;
                end
            end else if (state != ST_IDLE) begin
                // Address and write data are left as they were; only the
                // controls return to idle.
                state  <= ST_IDLE;
                ram_cs <= 1'b0;
                ram_we <= 1'b0;
                ram_oe <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ram_sp_arbiter.md
# ram_sp_arbiter

Two-requester round-robin arbiter and access sequencer for the single-port synchronous RAM (bidirectional data bus, `cs`/`we`/`oe` controls). The block sits between two masters, each with a valid/ready request channel and a response channel, and the RAM. It serialises their accesses, drives the RAM control and address lines from registers, owns the write direction of the shared data bus, and returns read data to the requester that issued the read.

## Interface
- `DATA_WIDTH`, 8, RAM word width
- `ADDR_WIDTH`, 8, RAM address width
- `clk`  in  1  clock; all activity on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `m0_req_valid` / `m1_req_valid`  in  1  request present
- `m0_req_ready` / `m1_req_ready`  out  1  request accepted this cycle (valid & ready)
- `m0_req_we` / `m1_req_we`  in  1  1 = write, 0 = read
- `m0_req_addr` / `m1_req_addr`  in  ADDR_WIDTH  word address
- `m0_req_wdata` / `m1_req_wdata`  in  DATA_WIDTH  write data
- `m0_rsp_valid` / `m1_rsp_valid`  out  1  one-cycle pulse, read data valid
- `m0_rsp_rdata` / `m1_rsp_rdata`  out  DATA_WIDTH  read data, held until that port's next response
- `ram_address`  out  ADDR_WIDTH  registered RAM address
- `ram_data`  inout  DATA_WIDTH  driven with the registered write data when `ram_we`=1, else high-Z
- `ram_cs`, `ram_we`, `ram_oe`  out  1  registered RAM controls

## Operation
- States: IDLE, WR, RD1, RD2.
- Acceptance is allowed in IDLE, WR and RD2. A requester's `req_ready` is high only when acceptance is allowed and that requester holds the grant. `req_ready` may depend combinationally on `req_valid` in the same cycle.
- Grant rules:
  - Only one requester valid: it wins.
  - Both valid: the requester that was not granted last wins.
  - The last-granted pointer updates on every accept and resets to m1, so m0 wins the first conflict.
- Accept of a write:
  - Next state is WR.
  - Register `ram_cs`=1, `ram_we`=1, `ram_oe`=0, plus the address and write data.
- Accept of a read:
  - Next state is RD1.
  - Register `ram_cs`=1, `ram_we`=0, `ram_oe`=1, plus the address, and record the requester ID.
- RD1 always goes to RD2, holding all controls and the address unchanged.
- In RD2, `ram_data` is captured into the recorded requester's `rsp_rdata`, and its `rsp_valid` is set for the next cycle.
- WR or RD2 with no accept: go to IDLE with `ram_cs`/`ram_we`/`ram_oe` = 0.
- WR or RD2 with an accept: go directly to the new access. No idle gap.
- Bus turnaround: the arbiter drives `ram_data` only while `ram_we`=1, and the RAM drives it only while `ram_we`=0. No turnaround cycle is inserted.
- Only one `rsp_valid` can be high in any cycle.

## Timing
- Reset values (any state, including mid-read):
  - State IDLE.
  - `ram_cs`/`ram_we`/`ram_oe` = 0, `ram_address` = 0, write-data register = 0, so `ram_data` is high-Z.
  - Both `rsp_valid` = 0, both `rsp_rdata` = 0, pointer = m1.
  - An aborted read produces no response.
- Write accepted at edge E0: controls are valid E0..E1; the RAM writes at E1. Occupancy is 1 cycle, so throughput is 1 write/cycle.
- Read accepted at E0:
  - The RAM registers its output at E1.
  - The arbiter captures at E2.
  - `rsp_valid` is high from E2 to E3.
  - Occupancy is 2 cycles; the next accept can occur at E2.
- A request held valid without a grant must keep its fields stable. The arbiter does not check this.

## Structure
- Shared package/header holds the state encoding constants (IDLE, WR, RD1, RD2) and the requester-ID constants (M0=0, M1=1).
- Natural sub-module: `rr_arb2`, a 2-way round-robin grant with a last-grant pointer and an update-on-accept input.
- The top level holds the FSM, the registered RAM controls, the tri-state driver and the per-port response registers.

## Test plan
- Reset, then m0 write addr 0x05 data 0xA5 → `m0_req_ready` high 1 cycle; next cycle `ram_cs`=1, `ram_we`=1, `ram_address`=0x05, `ram_data`=0xA5.
- m1 read addr 0x05 after that write → `m1_rsp_valid` pulses exactly 2 edges after accept with `m1_rsp_rdata`=0xA5; `m0_rsp_valid` stays 0.
- Both valid continuously:
  - m0 writes 0x10..0x13 and m1 writes 0x20..0x23.
  - Required: grants alternate m0, m1, m0, ….
  - Required: `ram_we` high every cycle (no bubbles), and a read-back of all 8 addresses matches.
- Back-to-back reads: m0 reads 0x10, then m0 reads 0x11 accepted in RD2 → responses exactly 2 cycles apart, in order.
- Read followed immediately by a write (accepted in RD2) → `ram_data` is never driven by the arbiter while `ram_we`=0, and the write lands at the correct address.
- `rst_n` low during RD1 → no `rsp_valid`, all RAM controls 0 on the next edge, and `ram_data` high-Z; a fresh read then works normally.
